id_decode: RTL
==============

Name: id_decode

Overview:
- Decode stage; consumes the 64-bit IF_ID word from fetch ({pc[31:0], instr[31:0]}).
- Splits the instruction into fields, reads the register file, and sign-extends the immediate.
- Applies a one-cycle load-use interlock and drives a registered ID_EX output with a valid/ready handshake.
- Sits between fetch and execute; the register-file write port comes from writeback.

Parameters:
- NREGS, 32, number of architectural registers; r0 reads as zero.
- XLEN, 32, data and pc width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- IF_ID  in  64  [63:32] pc, [31:0] instruction
- if_valid  in  1  IF_ID holds a valid instruction
- id_ready  out  1  decode accepts IF_ID this cycle; fetch holds IF_ID while low
- flush  in  1  branch redirect; kill in-flight decode work
- ex_ready  in  1  execute accepts ID_EX this cycle
- wb_we  in  1  register-file write enable
- wb_addr  in  5  write index
- wb_data  in  32  write data
- id_valid  out  1  ID_EX valid
- id_pc  out  32  pc of decoded instruction
- id_op  out  6  opcode
- id_rs_val  out  32  rs operand
- id_rt_val  out  32  rt operand
- id_imm  out  32  sign-extended instr[15:0]
- id_dest  out  5  destination register (0 = none)
- id_we  out  1  instruction writes a register
- id_illegal  out  1  opcode not recognised
- stall_count  out  32  number of load-use bubbles inserted

Behaviour:
- Instruction fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0].
- Opcode classes:
  - ALU_R 6'h00: reads rs, rt; dest = rd.
  - ADDI 6'h08: reads rs; dest = rt.
  - LOAD 6'h23: reads rs; dest = rt.
  - STORE 6'h2B: reads rs, rt; no dest.
  - BEQ 6'h04: reads rs, rt; no dest.
  - Any other opcode: id_illegal = 1, id_we = 0, id_dest = 0. The word is still issued so execute can trap.
- id_we = 1 only when the opcode has a dest and that dest != 0.
- Register read is combinational with write-through bypass: if wb_we and wb_addr == read index and the index != 0, the read returns wb_data.
- r0 always reads 0. Writes to r0 are ignored.
- Output advance condition: adv = !id_valid | ex_ready.
- Hazard condition: hz = id_valid & (id_op == LOAD) & (id_dest != 0) & (id_dest equals a register the incoming instruction reads).
- id_ready = flush | (adv & !hz). Combinational.
- Per rising edge, in priority order:
  1. Reset low: all outputs 0; state = RUN; stall_count = 0. Asynchronous, regardless of clock.
  2. flush: id_valid <= 0. Any IF_ID presented that cycle is consumed and discarded.
  3. !adv: hold all ID_EX outputs unchanged.
  4. adv & hz & if_valid: insert a bubble (id_valid <= 0); state = STALL; stall_count += 1, wrapping at 2^32.
  5. adv & if_valid: load ID_EX from the decoded IF_ID; id_valid <= 1; state = RUN.
  6. adv & !if_valid: id_valid <= 0.
- State machine: RUN and STALL.
  - STALL lasts exactly one cycle, because the bubble removes the LOAD from ID_EX.
  - STALL always returns to RUN.
- Latency: IF_ID to ID_EX is one cycle when unstalled; two cycles on a load-use hazard.
- Writeback to a register being read in the same cycle: the new value is issued.
- Reset mid-stall: returns to RUN with no pending bubble.
- Write port: the register file updates at the clock edge whenever wb_we is high. It is independent of stall, flush and handshake.

Decomposition:
- Shared package id_pkg holds:
  - opcode constants OP_ALU_R, OP_ADDI, OP_LOAD, OP_STORE, OP_BEQ
  - field-slice position constants
  - the RUN/STALL state encoding
- One natural sub-module, regfile: NREGS x XLEN, two read ports, one write port, bypass logic, r0 zero. The register contents have no reset.

Test Plan:
- Reset low mid-run, then released → all outputs 0 and id_ready = 1 with ex_ready = 1.
- IF_ID = {32'h4, 32'h0AAAAAAA}, if_valid = 1 → next cycle: id_valid = 1, id_pc = 4, id_op = 6'h02, id_illegal = 1, id_imm = 32'hFFFFAAAA, id_we = 0.
- Write r5 = 32'h1234 via wb; then issue ADDI r6, r5, 16'h0010 (32'h20A60010) → id_rs_val = 32'h1234, id_imm = 32'h10, id_dest = 6, id_we = 1. Repeat with the write occurring in the same cycle → bypass gives the same result.
- LOAD r7, 0(r1) (32'h8C270000), then ALU_R r8 = r7 + r2 (32'h00E24020) → one bubble (id_valid = 0 for one cycle), id_ready low for one cycle, stall_count = 1; the ALU op then issues.
- ex_ready = 0 for 3 cycles with a valid ID_EX → outputs stable and id_ready = 0 throughout. On release, the next instruction issues.
- flush = 1 while ex_ready = 0 and IF_ID valid → id_valid = 0 next cycle; IF_ID consumed (id_ready = 1); no issue of that instruction.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode-stage definitions: opcodes, field positions,
// interlock state encoding and the opcode classifier.
package id_pkg;

    localparam logic [5:0] OP_ALU_R = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LOAD  = 6'h23;
    localparam logic [5:0] OP_STORE = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam int OPC_LSB = 26;
    localparam int OPC_W   = 6;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int REG_W   = 5;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 16;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    typedef struct packed {
        logic legal;
        logic rd_rs;
        logic rd_rt;
        logic has_dst;
        logic dst_rd;
    } opc_t;

    // Which operands an opcode reads and where its destination lives.
    function automatic opc_t opc_class(input logic [OPC_W-1:0] op);
        opc_t c;
        c = '0;
        case (op)
            OP_ALU_R: c = '{legal: 1'b1, rd_rs: 1'b1, rd_rt: 1'b1,
                            has_dst: 1'b1, dst_rd: 1'b1};
            OP_ADDI:  c = '{legal: 1'b1, rd_rs: 1'b1, rd_rt: 1'b0,
                            has_dst: 1'b1, dst_rd: 1'b0};
            OP_LOAD:  c = '{legal: 1'b1, rd_rs: 1'b1, rd_rt: 1'b0,
                            has_dst: 1'b1, dst_rd: 1'b0};
            OP_STORE: c = '{legal: 1'b1, rd_rs: 1'b1, rd_rt: 1'b1,
                            has_dst: 1'b0, dst_rd: 1'b0};
            OP_BEQ:   c = '{legal: 1'b1, rd_rs: 1'b1, rd_rt: 1'b1,
                            has_dst: 1'b0, dst_rd: 1'b0};
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_decode_regfile.sv
// Two-read / one-write register file with write-through
// bypass; r0 is hard-wired to zero and never written.
module id_decode_regfile #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic [AW-1:0]   i_ra,
    input  logic [AW-1:0]   i_rb,
    output logic [XLEN-1:0] o_ra,
    output logic [XLEN-1:0] o_rb,
    input  logic            i_we,
    input  logic [AW-1:0]   i_wa,
    input  logic [XLEN-1:0] i_wd
);

    logic [XLEN-1:0] r_mem [NREGS];

    logic w_wr;
    assign w_wr = i_we && (i_wa != '0);

    // Storage update; contents are deliberately left unreset.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    // Read ports: r0 forced to zero, same-cycle write forwarded.
    always_comb begin
        o_ra = r_mem[i_ra];
        o_rb = r_mem[i_rb];
        if (w_wr && (i_wa == i_ra)) begin
            o_ra = i_wd;
        end
        if (w_wr && (i_wa == i_rb)) begin
            o_rb = i_wd;
        end
        if (i_ra == '0) begin
            o_ra = '0;
        end
        if (i_rb == '0) begin
            o_rb = '0;
        end
    end

endmodule

// File: rtl/id_decode.sv
// Decode stage: field split, register read, immediate extend,
// load-use interlock and registered ID_EX with handshake.
module id_decode #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2*XLEN-1:0] IF_ID,
    input  logic              if_valid,
    output logic              id_ready,
    input  logic              flush,
    input  logic              ex_ready,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              id_valid,
    output logic [XLEN-1:0]   id_pc,
    output logic [5:0]        id_op,
    output logic [XLEN-1:0]   id_rs_val,
    output logic [XLEN-1:0]   id_rt_val,
    output logic [XLEN-1:0]   id_imm,
    output logic [4:0]        id_dest,
    output logic              id_we,
    output logic              id_illegal,
    output logic [31:0]       stall_count
);

    import id_pkg::*;

    logic [31:0]       w_instr;
    logic [XLEN-1:0]   w_pc;
    logic [OPC_W-1:0]  w_op;
    logic [REG_W-1:0]  w_rs;
    logic [REG_W-1:0]  w_rt;
    logic [REG_W-1:0]  w_rd;
    logic [IMM_W-1:0]  w_imm16;
    logic [XLEN-1:0]   w_imm;
    opc_t              w_cls;
    logic [REG_W-1:0]  w_dest;
    logic              w_we;
    logic [XLEN-1:0]   w_rs_val;
    logic [XLEN-1:0]   w_rt_val;
    logic              w_adv;
    logic              w_hz;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [OPC_W-1:0]  r_op;
    logic [XLEN-1:0]   r_rs_val;
    logic [XLEN-1:0]   r_rt_val;
    logic [XLEN-1:0]   r_imm;
    logic [REG_W-1:0]  r_dest;
    logic              r_we;
    logic              r_illegal;
    logic [31:0]       r_stalls;

    logic              w_valid_n;
    logic [XLEN-1:0]   w_pc_n;
    logic [OPC_W-1:0]  w_op_n;
    logic [XLEN-1:0]   w_rs_val_n;
    logic [XLEN-1:0]   w_rt_val_n;
    logic [XLEN-1:0]   w_imm_n;
    logic [REG_W-1:0]  w_dest_n;
    logic              w_we_n;
    logic              w_illegal_n;
    logic [31:0]       w_stalls_n;

    assign w_instr = IF_ID[31:0];
    assign w_pc    = IF_ID[2*XLEN-1:XLEN];
    assign w_op    = w_instr[OPC_LSB +: OPC_W];
    assign w_rs    = w_instr[RS_LSB +: REG_W];
    assign w_rt    = w_instr[RT_LSB +: REG_W];
    assign w_rd    = w_instr[RD_LSB +: REG_W];
    assign w_imm16 = w_instr[IMM_LSB +: IMM_W];
    assign w_imm   = {{(XLEN-IMM_W){w_imm16[IMM_W-1]}}, w_imm16};
    assign w_cls   = opc_class(w_op);

    assign w_dest = !(w_cls.legal && w_cls.has_dst) ? '0 :
                    (w_cls.dst_rd ? w_rd : w_rt);
    assign w_we   = (w_dest != '0);

    id_decode_regfile #(
        .NREGS (NREGS),
        .XLEN  (XLEN),
        .AW    (REG_W)
    ) u_rf (
        .clock (clock),
        .i_ra  (w_rs),
        .i_rb  (w_rt),
        .o_ra  (w_rs_val),
        .o_rb  (w_rt_val),
        .i_we  (wb_we),
        .i_wa  (wb_addr),
        .i_wd  (wb_data)
    );

    assign w_adv = !r_valid || ex_ready;

    assign w_hz = r_valid && (r_op == OP_LOAD) && (r_dest != '0) &&
                  ((w_cls.rd_rs && (w_rs == r_dest)) ||
                   (w_cls.rd_rt && (w_rt == r_dest)));

    assign id_ready = flush || (w_adv && !w_hz);

    // Next ID_EX contents and interlock state, by edge priority.
    always_comb begin
        w_valid_n   = r_valid;
        w_pc_n      = r_pc;
        w_op_n      = r_op;
        w_rs_val_n  = r_rs_val;
        w_rt_val_n  = r_rt_val;
        w_imm_n     = r_imm;
        w_dest_n    = r_dest;
        w_we_n      = r_we;
        w_illegal_n = r_illegal;
        w_stalls_n  = r_stalls;
        w_state_nxt = ST_RUN;
        if (flush) begin
            w_valid_n = 1'b0;
        end else if (!w_adv) begin
            w_valid_n = r_valid;
        end else if (w_hz && if_valid) begin
            w_valid_n  = 1'b0;
            w_stalls_n = r_stalls + 32'd1;
        end else if (if_valid) begin
            w_valid_n   = 1'b1;
            w_pc_n      = w_pc;
            w_op_n      = w_op;
            w_rs_val_n  = w_rs_val;
            w_rt_val_n  = w_rt_val;
            w_imm_n     = w_imm;
            w_dest_n    = w_dest;
            w_we_n      = w_we;
            w_illegal_n = !w_cls.legal;
        end else begin
            w_valid_n = 1'b0;
        end
        unique case (r_state)
            ST_RUN: begin
                if (!flush && w_adv && w_hz && if_valid) begin
                    w_state_nxt = ST_STALL;
                end
            end
            ST_STALL: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // ID_EX pipeline register, stall counter and interlock state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_RUN;
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_op      <= '0;
            r_rs_val  <= '0;
            r_rt_val  <= '0;
            r_imm     <= '0;
            r_dest    <= '0;
            r_we      <= 1'b0;
            r_illegal <= 1'b0;
            r_stalls  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_valid   <= w_valid_n;
            r_pc      <= w_pc_n;
            r_op      <= w_op_n;
            r_rs_val  <= w_rs_val_n;
            r_rt_val  <= w_rt_val_n;
            r_imm     <= w_imm_n;
            r_dest    <= w_dest_n;
            r_we      <= w_we_n;
            r_illegal <= w_illegal_n;
            r_stalls  <= w_stalls_n;
        end
    end

    assign id_valid    = r_valid;
    assign id_pc       = r_pc;
    assign id_op       = r_op;
    assign id_rs_val   = r_rs_val;
    assign id_rt_val   = r_rt_val;
    assign id_imm      = r_imm;
    assign id_dest     = r_dest;
    assign id_we       = r_we;
    assign id_illegal  = r_illegal;
    assign stall_count = r_stalls;

endmodule
